// File: rtl/ram_cmd_arbiter_pkg.sv
// Shared types for the RAM command-port arbiter: RAM command codes and FSM state encoding.
package ram_arb_pkg;
  localparam int CMD_W = 2;

  typedef enum logic [CMD_W-1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } ram_cmd_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    DATA    = 2'd2,
    WAIT_RD = 2'd3
  } arb_state_e;
endpackage

// File: rtl/ram_cmd_arbiter_if.sv
// Requester, response and RAM command/read-data signals of the arbiter, bundled as one interface.
interface ram_cmd_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rsp_valid;
  logic [IW-1:0]             rsp_id;
  logic                      rsp_err;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      ram_rx_valid;
  logic [DATA_W+1:0]         ram_din;
  logic                      ram_tx_valid;
  logic [DATA_W-1:0]         ram_dout;

  // arbiter side
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ram_tx_valid, ram_dout,
    output req_ready, rsp_valid, rsp_id, rsp_err, rsp_rdata, ram_rx_valid, ram_din
  );

  // requesters + RAM side
  modport master (
    output req_valid, req_we, req_addr, req_wdata, ram_tx_valid, ram_dout,
    input  req_ready, rsp_valid, rsp_id, rsp_err, rsp_rdata, ram_rx_valid, ram_din
  );
endinterface

// File: rtl/ram_cmd_arbiter_rr.sv
// Round-robin picker: first set req at or after ptr, wrapping, as one-hot grant plus index.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  logic found;
  int   j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (enable && !found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end
endmodule

// File: rtl/ram_cmd_arbiter.sv
// Shares the RAM command port among NUM_REQ requesters as two-beat {cmd,payload} sequences.
// Define ADDR_CACHE_EN to skip the address beat when it repeats the last one of the same kind.
module ram_cmd_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int RD_TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst,
  ram_cmd_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(RD_TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_ADDR = 2'(ADDR);
  localparam logic [1:0] ST_DATA = 2'(DATA);
  localparam logic [1:0] ST_WAIT = 2'(WAIT_RD);

  logic [1:0]         state;
  logic [IW-1:0]      ptr, g_idx, lat_id;
  logic [NUM_REQ-1:0] grant;
  logic               g_we, lat_we, skip;
  logic [ADDR_W-1:0]  g_addr, lat_addr;
  logic [DATA_W-1:0]  lat_wdata;
  logic [CW-1:0]      cnt;
  logic               rsp_valid, rsp_err;
  logic [IW-1:0]      rsp_id;
  logic [DATA_W-1:0]  rsp_rdata;
  logic [CMD_W-1:0]   cmd;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req    (bus.req_valid),
    .ptr    (ptr),
    .enable (state == ST_IDLE && !rst),
    .grant  (grant),
    .idx    (g_idx)
  );

  assign g_we          = bus.req_we[g_idx];
  assign g_addr        = bus.req_addr[int'(g_idx)*ADDR_W +: ADDR_W];
  assign bus.req_ready = grant;

`ifdef ADDR_CACHE_EN
  logic              last_wr_vld, last_rd_vld;
  logic [ADDR_W-1:0] last_wr_addr, last_rd_addr;

  assign skip = g_we ? (last_wr_vld && last_wr_addr == g_addr)
                     : (last_rd_vld && last_rd_addr == g_addr);

  // the cache follows what the RAM last saw on an address beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_wr_vld  <= 1'b0;
      last_rd_vld  <= 1'b0;
      last_wr_addr <= '0;
      last_rd_addr <= '0;
    end else if (state == ST_ADDR) begin
      if (lat_we) begin
        last_wr_vld  <= 1'b1;
        last_wr_addr <= lat_addr;
      end else begin
        last_rd_vld  <= 1'b1;
        last_rd_addr <= lat_addr;
      end
    end
  end
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_id    <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      // response fields are single-cycle and read as zero otherwise
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      case (state)
        ST_IDLE: if (|grant) begin
          lat_we    <= g_we;
          lat_addr  <= g_addr;
          lat_wdata <= bus.req_wdata[int'(g_idx)*DATA_W +: DATA_W];
          lat_id    <= g_idx;
          ptr       <= (g_idx == IW'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
          state     <= skip ? ST_DATA : ST_ADDR;
        end
        ST_ADDR: state <= ST_DATA;
        ST_DATA: if (lat_we) begin
          rsp_valid <= 1'b1;
          rsp_id    <= lat_id;
          state     <= ST_IDLE;
        end else begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: if (bus.ram_tx_valid) begin
          rsp_valid <= 1'b1;
          rsp_id    <= lat_id;
          rsp_rdata <= bus.ram_dout;
          state     <= ST_IDLE;
        end else if (cnt == CW'(RD_TIMEOUT - 1)) begin
          rsp_valid <= 1'b1;
          rsp_id    <= lat_id;
          rsp_err   <= 1'b1;
          state     <= ST_IDLE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.ram_rx_valid = 1'b0;
    bus.ram_din      = '0;
    cmd              = '0;
    case (state)
      ST_ADDR: begin
        cmd              = lat_we ? CMD_W'(WR_ADDR) : CMD_W'(RD_ADDR);
        bus.ram_rx_valid = 1'b1;
        bus.ram_din      = {cmd, lat_addr};
      end
      ST_DATA: begin
        cmd              = lat_we ? CMD_W'(WR_DATA) : CMD_W'(RD_DATA);
        bus.ram_rx_valid = 1'b1;
        bus.ram_din      = {cmd, lat_we ? lat_wdata : {DATA_W{1'b0}}};
      end
      default: ;
    endcase
  end

  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = rsp_id;
  assign bus.rsp_err   = rsp_err;
  assign bus.rsp_rdata = rsp_rdata;
endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Directed bench for ram_cmd_arbiter: transaction table plus grant-order and reset sequences.
module tb_ram_cmd_arbiter;
  localparam int NR = 2, AW = 8, DW = 8, TO = 15;
`ifdef ADDR_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ram_cmd_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_cmd_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // behavioural RAM: read data appears in the cycle after the RD_DATA beat
  logic [7:0] mem [256];
  logic [7:0] waddr, raddr;
  bit pend;
  bit tx_en = 1'b1;
  initial begin
    bus.ram_tx_valid = 1'b0;
    bus.ram_dout     = '0;
    pend = 1'b0; waddr = '0; raddr = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    forever begin
      @(negedge clk);
      bus.ram_tx_valid = pend;
      bus.ram_dout     = pend ? mem[raddr] : 8'h00;
      pend = 1'b0;
      if (bus.ram_rx_valid && !rst) begin
        case (bus.ram_din[9:8])
          2'b00: waddr = bus.ram_din[7:0];
          2'b01: mem[waddr] = bus.ram_din[7:0];
          2'b10: raddr = bus.ram_din[7:0];
          default: pend = tx_en;
        endcase
      end
    end
  end

  task automatic chk_zero(input string nm);
    chk({nm, " ready"}, 32'(bus.req_ready), 0);
    chk({nm, " rsp_valid"}, 32'(bus.rsp_valid), 0);
    chk({nm, " rsp_id"}, 32'(bus.rsp_id), 0);
    chk({nm, " rsp_err"}, 32'(bus.rsp_err), 0);
    chk({nm, " rsp_rdata"}, 32'(bus.rsp_rdata), 0);
    chk({nm, " rx_valid"}, 32'(bus.ram_rx_valid), 0);
    chk({nm, " din"}, 32'(bus.ram_din), 0);
  endtask

  // one transaction from requester id; cycle 0 is the grant cycle
  task automatic txn(input int id, input bit we, input logic [7:0] addr, input logic [7:0] wdata,
                     input logic [1:0] extra, input int nb, input logic [9:0] b0, input logic [9:0] b1,
                     input logic [7:0] erd, input int lat, input bit err, input string nm);
    logic [9:0] beats[$];
    bit got = 1'b0;
    @(negedge clk);
    bus.req_valid = 2'(1 << id) | extra;
    bus.req_we    = {we, we};
    bus.req_addr[id*8 +: 8]  = addr;
    bus.req_wdata[id*8 +: 8] = wdata;
    #1 chk({nm, " ready"}, 32'(bus.req_ready), 32'(1 << id));
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      if (bus.ram_rx_valid) beats.push_back(bus.ram_din);
      if (bus.rsp_valid) begin
        got = 1'b1;
        chk({nm, " latency"}, c, lat);
        chk({nm, " rsp_id"}, 32'(bus.rsp_id), id);
        chk({nm, " rsp_err"}, 32'(bus.rsp_err), 32'(err));
        chk({nm, " rsp_rdata"}, 32'(bus.rsp_rdata), 32'(erd));
      end
    end
    chk({nm, " rsp seen"}, 32'(got), 1);
    chk({nm, " beats"}, beats.size(), nb);
    if (beats.size() > 0) chk({nm, " beat0"}, 32'(beats[0]), 32'(b0));
    if (beats.size() > 1) chk({nm, " beat1"}, 32'(beats[1]), 32'(b1));
  endtask

  typedef struct {
    int id; bit we; logic [7:0] addr; logic [7:0] wdata; logic [1:0] extra;
    int nb; logic [9:0] b0; logic [9:0] b1; logic [7:0] rd; int lat; bit err; bit txe;
  } vec_t;
  vec_t vt [9];
  int order [4] = '{0, 1, 0, 1};
  int gcyc [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ng, nr;
    vt[0] = '{0, 1'b1, 8'h12, 8'hA5, 2'b00, 2, 10'h012, 10'h1A5, 8'h00, 3, 1'b0, 1'b1};
    vt[1] = '{0, 1'b0, 8'h12, 8'h00, 2'b00, 2, 10'h212, 10'h300, 8'hA5, 4, 1'b0, 1'b1};
    vt[2] = '{1, 1'b0, 8'h55, 8'h00, 2'b00, 2, 10'h255, 10'h300, 8'h00, 3 + TO, 1'b1, 1'b0};
    vt[3] = '{1, 1'b1, 8'h40, 8'h5C, 2'b00, 2, 10'h040, 10'h15C, 8'h00, 3, 1'b0, 1'b1};
    vt[4] = '{0, 1'b0, 8'h40, 8'h00, 2'b00, 2, 10'h240, 10'h300, 8'h5C, 4, 1'b0, 1'b1};
    vt[5] = '{0, 1'b0, 8'h40, 8'h00, 2'b00, CACHE ? 1 : 2, CACHE ? 10'h300 : 10'h240,
              CACHE ? 10'h000 : 10'h300, 8'h5C, CACHE ? 3 : 4, 1'b0, 1'b1};
    vt[6] = '{1, 1'b1, 8'hFF, 8'h00, 2'b00, 2, 10'h0FF, 10'h100, 8'h00, 3, 1'b0, 1'b1};
    vt[7] = '{0, 1'b1, 8'h00, 8'hFF, 2'b10, 2, 10'h000, 10'h1FF, 8'h00, 3, 1'b0, 1'b1};
    vt[8] = '{1, 1'b0, 8'hFF, 8'h00, 2'b00, 2, 10'h2FF, 10'h300, 8'h00, 4, 1'b0, 1'b1};

    bus.req_valid = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
    #1 rst = 1'b1;
    #2 chk_zero("reset");
    bus.req_valid = 2'b11;
    @(negedge clk); #1 chk("reset ready held", 32'(bus.req_ready), 0);
    @(negedge clk); rst = 1'b0; bus.req_valid = '0;
    @(negedge clk); #1 chk_zero("post reset");

    // both requesters hold writes: grants alternate, one every 3 cycles
    @(negedge clk);
    bus.req_valid = 2'b11; bus.req_we = 2'b11;
    bus.req_addr = {8'h21, 8'h20}; bus.req_wdata = {8'h31, 8'h30};
    ng = 0; nr = 0;
    for (int c = 0; c < 40 && nr < 4; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (ng >= 4) bus.req_valid = '0;
      end
      #1;
      if (bus.rsp_valid) begin
        chk("rr rsp_id", 32'(bus.rsp_id), order[nr]);
        chk("rr rsp latency", c, gcyc[nr] + 3);
        nr++;
      end
      if (bus.req_ready != '0 && ng < 4) begin
        chk("rr onehot", 32'($onehot(bus.req_ready)), 1);
        chk("rr grant", 32'(bus.req_ready), 32'(1 << order[ng]));
        gcyc[ng] = c;
        ng++;
      end
    end
    chk("rr grants", ng, 4);
    chk("rr rsps", nr, 4);

    for (int i = 0; i < 9; i++) begin
      tx_en = vt[i].txe;
      txn(vt[i].id, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].extra, vt[i].nb,
          vt[i].b0, vt[i].b1, vt[i].rd, vt[i].lat, vt[i].err, $sformatf("v%0d", i));
      tx_en = 1'b1;
    end

    // reset during the DATA beat of a read drops it
    @(negedge clk);
    bus.req_valid = 2'b01; bus.req_we = 2'b00; bus.req_addr[7:0] = 8'h66;
    #1 chk("rst txn ready", 32'(bus.req_ready), 1);
    @(negedge clk); bus.req_valid = '0;
    #1 chk("rst txn addr beat", 32'(bus.ram_din), 32'h266);
    @(negedge clk);
    #1 chk("rst txn data beat", 32'(bus.ram_din), 32'h300);
    rst = 1'b1;
    #1 chk_zero("mid-read reset");
    bus.req_valid = 2'b11;
    #1 chk("mid-read reset ready", 32'(bus.req_ready), 0);
    @(negedge clk);
    @(negedge clk); rst = 1'b0; bus.req_valid = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      chk("dropped no rsp", 32'(bus.rsp_valid), 0);
      chk("dropped no cmd", 32'(bus.ram_rx_valid), 0);
    end
    txn(0, 1'b1, 8'h70, 8'h01, 2'b10, 2, 10'h070, 10'h101, 8'h00, 3, 1'b0, "after reset");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
